// File: rtl/cpu_bus_bridge.sv
// Bridges NUM_CH SRAM-style CPU memory ports onto one handshaked bus.
// Fixed-priority arbitration runs one transaction at a time and holds the pipeline stalled until every enabled channel is done.
module cpu_bus_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_wen,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH*DATA_W-1:0]   ch_rdata,
  output logic [NUM_CH-1:0]          ch_done,
  input  logic                       flush,
  output logic                       stall,
  output logic                       bus_req,
  output logic                       bus_wr,
  output logic [DATA_W/8-1:0]        bus_wstrb,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [DATA_W-1:0]          bus_wdata,
  input  logic                       bus_addr_ok,
  input  logic                       bus_data_ok,
  input  logic [DATA_W-1:0]          bus_rdata,
  output logic [1:0]                 dbg_state_o
);

  localparam int BE_W = DATA_W / 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                   state_q;
  logic [CH_W-1:0]          grant_q;
  logic                     disc_q;
  logic                     bus_req_q;
  logic                     bus_wr_q;
  logic [BE_W-1:0]          bus_wstrb_q;
  logic [ADDR_W-1:0]        bus_addr_q;
  logic [DATA_W-1:0]        bus_wdata_q;
  logic [NUM_CH-1:0]        done_q;
  logic [NUM_CH*DATA_W-1:0] rdata_q;

  logic [NUM_CH-1:0]        pend;
  logic                     any_pend;
  logic [CH_W-1:0]          grant_d;
  logic [ADDR_W-1:0]        sel_addr_d;
  logic [DATA_W-1:0]        sel_wdata_d;
  logic [BE_W-1:0]          sel_wen_d;

  // Scan from highest to lowest index so the lowest pending channel wins.
  always_comb begin
    pend        = ch_en & ~done_q;
    any_pend    = |pend;
    grant_d     = '0;
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    sel_wen_d   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant_d     = CH_W'(i);
        sel_addr_d  = ch_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_d = ch_wdata[i*DATA_W +: DATA_W];
        sel_wen_d   = ch_wen[i*BE_W +: BE_W];
      end
    end
    stall = any_pend | (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      disc_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_wstrb_q <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
    end else begin
      // A pipeline advance or a flush retires all completion flags.
      if (flush || !stall) done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (any_pend && !flush) begin
            grant_q     <= grant_d;
            bus_addr_q  <= sel_addr_d;
            bus_wdata_q <= sel_wdata_d;
            bus_wstrb_q <= sel_wen_d;
            bus_wr_q    <= |sel_wen_d;
            bus_req_q   <= 1'b1;
            disc_q      <= 1'b0;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) disc_q <= 1'b1;
          if (bus_addr_ok) begin
            bus_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) disc_q <= 1'b1;
          if (bus_data_ok) begin
            // A flush arriving with the response discards it as well.
            if (!disc_q && !flush) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (grant_q == CH_W'(i)) begin
                  done_q[i] <= 1'b1;
                  if (!bus_wr_q) rdata_q[i*DATA_W +: DATA_W] <= bus_rdata;
                end
              end
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ch_rdata    = rdata_q;
  assign ch_done     = done_q;
  assign bus_req     = bus_req_q;
  assign bus_wr      = bus_wr_q;
  assign bus_wstrb   = bus_wstrb_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge: the bench plays both the CPU and the bus slave cycle by cycle.
module tb_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ch_en;
  logic [7:0]  ch_wen;
  logic [63:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [63:0] ch_rdata;
  logic [1:0]  ch_done;
  logic        flush;
  logic        stall;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_bus_bridge #(.ADDR_W(32), .DATA_W(32), .NUM_CH(2)) dut (
    .clk(clk), .rst(rst),
    .ch_en(ch_en), .ch_wen(ch_wen), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .ch_done(ch_done), .flush(flush), .stall(stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .dbg_state_o(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ch_en = '0; ch_wen = '0; ch_addr = '0; ch_wdata = '0;
    flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

    // Reset values; stall follows ch_en combinationally.
    tick(); ch_en = 2'b01; #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_wr", bus_wr, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_done", ch_done, 0);
    chk("rst_rdata", ch_rdata, 0);
    chk("rst_stall_en", stall, 1);
    ch_en = 2'b00; #1;
    chk("rst_stall_noen", stall, 0);
    tick(); rst = 1'b0;

    // Single read on ch1.
    tick(); ch_en = 2'b10; ch_addr[63:32] = 32'hBFC00000; #1;
    chk("rd_c0_stall", stall, 1);
    chk("rd_c0_req", bus_req, 0);
    tick(); bus_addr_ok = 1'b1; #1;
    chk("rd_c1_req", bus_req, 1);
    chk("rd_c1_addr", bus_addr, 32'hBFC00000);
    chk("rd_c1_wr", bus_wr, 0);
    chk("rd_c1_stall", stall, 1);
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C080001; #1;
    chk("rd_c2_req", bus_req, 0);
    chk("rd_c2_stall", stall, 1);
    chk("rd_c2_state", dbg_state, 2);
    tick(); bus_data_ok = 1'b0; #1;
    chk("rd_c3_rdata", ch_rdata[63:32], 32'h3C080001);
    chk("rd_c3_done", ch_done, 2'b10);
    chk("rd_c3_stall", stall, 0);
    chk("rd_c3_state", dbg_state, 0);

    // Back-to-back: new ch1 request right after the advance.
    tick(); ch_addr[63:32] = 32'hBFC00004; #1;
    chk("b2b_c4_done", ch_done, 0);
    chk("b2b_c4_stall", stall, 1);
    chk("b2b_c4_req", bus_req, 0);
    tick(); bus_addr_ok = 1'b1; #1;
    chk("b2b_c5_req", bus_req, 1);
    chk("b2b_c5_addr", bus_addr, 32'hBFC00004);
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h24080002; #1;
    tick(); bus_data_ok = 1'b0; #1;
    chk("b2b_rdata", ch_rdata[63:32], 32'h24080002);
    chk("b2b_done", ch_done, 2'b10);
    tick(); ch_en = 2'b00; #1;
    chk("b2b_idle_req", bus_req, 0);
    chk("b2b_idle_done", ch_done, 0);

    // Arbitration: ch0 write and ch1 read in the same cycle.
    tick();
    ch_en = 2'b11; ch_wen = 8'h03; ch_wdata[31:0] = 32'hDEADBEEF;
    ch_addr[31:0] = 32'h00001000; ch_addr[63:32] = 32'h00002000; #1;
    chk("arb_a0_stall", stall, 1);
    tick(); bus_addr_ok = 1'b1; #1;
    chk("arb_a1_req", bus_req, 1);
    chk("arb_a1_wr", bus_wr, 1);
    chk("arb_a1_wstrb", bus_wstrb, 4'b0011);
    chk("arb_a1_addr", bus_addr, 32'h00001000);
    chk("arb_a1_wdata", bus_wdata, 32'hDEADBEEF);
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAAAAAA; #1;
    tick(); bus_data_ok = 1'b0; #1;
    chk("arb_a3_done", ch_done, 2'b01);
    chk("arb_a3_stall", stall, 1);
    chk("arb_a3_req", bus_req, 0);
    chk("arb_a3_rdata0", ch_rdata[31:0], 0);
    tick(); bus_addr_ok = 1'b1; #1;
    chk("arb_a4_req", bus_req, 1);
    chk("arb_a4_addr", bus_addr, 32'h00002000);
    chk("arb_a4_wr", bus_wr, 0);
    chk("arb_a4_wstrb", bus_wstrb, 0);
    chk("arb_a4_stall", stall, 1);
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h55667788; #1;
    chk("arb_a5_stall", stall, 1);
    tick(); bus_data_ok = 1'b0; #1;
    chk("arb_a6_done", ch_done, 2'b11);
    chk("arb_a6_stall", stall, 0);
    chk("arb_a6_rdata1", ch_rdata[63:32], 32'h55667788);
    chk("arb_a6_req", bus_req, 0);
    tick(); ch_en = 2'b00; ch_wen = '0; #1;
    chk("arb_a7_req", bus_req, 0);
    chk("arb_a7_done", ch_done, 0);

    // Slow slave: addr_ok after 5 cycles of bus_req, data_ok 3 cycles later.
    tick(); ch_en = 2'b01; ch_addr[31:0] = 32'h00003000; #1;
    for (int k = 0; k < 5; k++) begin
      tick(); bus_addr_ok = (k == 4); #1;
      chk("slow_req", bus_req, 1);
      chk("slow_addr", bus_addr, 32'h00003000);
      chk("slow_stall_req", stall, 1);
    end
    for (int k = 0; k < 3; k++) begin
      tick(); bus_addr_ok = 1'b0; bus_data_ok = (k == 2); bus_rdata = 32'hCAFEF00D; #1;
      chk("slow_wait_req", bus_req, 0);
      chk("slow_stall_wait", stall, 1);
    end
    tick(); bus_data_ok = 1'b0; #1;
    chk("slow_done", ch_done, 2'b01);
    chk("slow_rdata", ch_rdata[31:0], 32'hCAFEF00D);
    chk("slow_stall_end", stall, 0);
    tick(); ch_en = 2'b00; #1;

    // Flush one cycle after addr_ok: response must be dropped.
    tick(); ch_en = 2'b01; ch_addr[31:0] = 32'h00004000; #1;
    tick(); bus_addr_ok = 1'b1; #1;
    chk("fl_req", bus_req, 1);
    tick(); bus_addr_ok = 1'b0; flush = 1'b1; ch_en = 2'b00; #1;
    chk("fl_state_wait", dbg_state, 2);
    chk("fl_stall", stall, 1);
    tick(); flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h12345678; #1;
    chk("fl_stall_hold", stall, 1);
    tick(); bus_data_ok = 1'b0; #1;
    chk("fl_rdata_kept", ch_rdata[31:0], 32'hCAFEF00D);
    chk("fl_done", ch_done, 0);
    chk("fl_state_idle", dbg_state, 0);
    chk("fl_req_none", bus_req, 0);
    chk("fl_stall_end", stall, 0);
    tick(); #1;
    chk("fl_req_none2", bus_req, 0);

    // Flush in IDLE blocks the grant, then reset arrives mid-REQ.
    tick(); ch_en = 2'b01; ch_addr[31:0] = 32'h00005000; flush = 1'b1; #1;
    chk("fi_stall", stall, 1);
    tick(); flush = 1'b0; #1;
    chk("fi_req_blocked", bus_req, 0);
    chk("fi_state", dbg_state, 0);
    tick(); #1;
    chk("fi_req_granted", bus_req, 1);
    chk("fi_addr", bus_addr, 32'h00005000);
    rst = 1'b1;
    tick(); rst = 1'b0; ch_en = 2'b00; #1;
    chk("rmid_req", bus_req, 0);
    chk("rmid_state", dbg_state, 0);
    chk("rmid_done", ch_done, 0);
    chk("rmid_rdata", ch_rdata, 0);
    chk("rmid_addr", bus_addr, 0);
    chk("rmid_stall", stall, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
